// File: rtl/usb_rx_wire_sampler_if.sv
// Receive-side handshake between the wire sampler and the SIE line-state receiver.
interface usb_rx_wire_sampler_if;
    logic [1:0] RxWireDataOut;
    logic       RxWireDataWEn;
    logic       RxWireReady;

    modport master (
        output RxWireDataOut,
        output RxWireDataWEn,
        input  RxWireReady
    );

    modport slave (
        input  RxWireDataOut,
        input  RxWireDataWEn,
        output RxWireReady
    );
endinterface

// File: rtl/usb_rx_wire_sampler.sv
// USB receive front end: pin synchroniser, optional deglitch (USB_RX_GLITCH_FILTER_EN),
// edge-locked mid-bit sampling and a small line-state FIFO toward the SIE receiver.
module usb_rx_wire_sampler #(
    parameter int OVERSAMPLE = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            USBWireDataIn,
    input  logic                  rxEn,
    input  logic                  lowSpeed,
    output logic                  rxOverflow,
    usb_rx_wire_sampler_if.master rx_bus
);
    localparam int CNT_W = $clog2(OVERSAMPLE * 8);
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] FS_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] FS_HALF = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] LS_LAST = CNT_W'(OVERSAMPLE * 8 - 1);
    localparam logic [CNT_W-1:0] LS_HALF = CNT_W'(OVERSAMPLE * 4);

    logic [1:0]       s1, s, f, f_prev;
    logic             low_speed_q;
    logic             line_edge;
    logic [CNT_W-1:0] cnt, period_last, period_half;
    logic             strobe;

    // NOTE: every clocked register uses <= so all flops see pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 2'b00;
            s  <= 2'b00;
        end else begin
            s1 <= USBWireDataIn;
            s  <= s1;
        end
    end

`ifdef USB_RX_GLITCH_FILTER_EN
    logic [1:0] s_d;

    // A level must be seen on two consecutive clocks before it is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s_d <= 2'b00;
            f   <= 2'b00;
        end else begin
            s_d <= s;
            if (s == s_d) f <= s;
        end
    end
`else
    assign f = s;
`endif

    assign line_edge   = (f != f_prev);
    assign period_last = lowSpeed ? LS_LAST : FS_LAST;
    assign period_half = lowSpeed ? LS_HALF : FS_HALF;
    assign strobe      = rxEn && (cnt == period_half);

    // The edge cycle itself is phase 0, so the counter restarts at 1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            f_prev      <= 2'b00;
            low_speed_q <= 1'b0;
            cnt         <= '0;
        end else begin
            f_prev      <= f;
            low_speed_q <= lowSpeed;
            if (!rxEn || (lowSpeed != low_speed_q))
                cnt <= '0;
            else if (line_edge)
                cnt <= CNT_W'(1);
            else if (cnt == period_last)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
        end
    end

    logic [1:0]  mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic        empty, full, pop, push;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = !empty && rx_bus.RxWireReady;
    assign push  = strobe && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr       <= '0;
            rptr       <= '0;
            rxOverflow <= 1'b0;
        end else if (!rxEn) begin
            wptr       <= '0;
            rptr       <= '0;
            rxOverflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + (AW + 1)'(1);
            if (pop)  rptr <= rptr + (AW + 1)'(1);
            if (strobe && full && !pop) rxOverflow <= 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers define validity and the head is gated while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= f;
    end

    assign rx_bus.RxWireDataWEn = !empty;
    assign rx_bus.RxWireDataOut = empty ? 2'b00 : mem[rptr[AW-1:0]];
endmodule

// File: tb/tb_usb_rx_wire_sampler.sv
// Directed bench for usb_rx_wire_sampler, default build (glitch filter off), OVERSAMPLE=4, FIFO_DEPTH=4.
module tb_usb_rx_wire_sampler;
    localparam int OVERSAMPLE = 4;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] pins;
    logic       rx_en;
    logic       low_speed;
    logic       overflow;

    usb_rx_wire_sampler_if bus ();

    usb_rx_wire_sampler #(
        .OVERSAMPLE(OVERSAMPLE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .USBWireDataIn(pins),
        .rxEn         (rx_en),
        .lowSpeed     (low_speed),
        .rxOverflow   (overflow),
        .rx_bus       (bus)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    logic       exp_ovf     = 1'b0;
    int         exp_cyc[$];
    logic [1:0] exp_dat[$];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic expect_push(input int c, input logic [1:0] d);
        exp_cyc.push_back(c);
        exp_dat.push_back(d);
    endtask

    // Non-stalling consumer: each push shows up as a one-cycle valid pulse.
    task automatic run_free(input int last, input string tag);
        while (cyc < last) begin
            tick();
            if (exp_cyc.size() != 0 && exp_cyc[0] == cyc) begin
                chk({tag, "_wen"}, {1'b0, bus.RxWireDataWEn}, 2'b01);
                chk({tag, "_data"}, bus.RxWireDataOut, exp_dat[0]);
                void'(exp_cyc.pop_front());
                void'(exp_dat.pop_front());
            end else begin
                chk({tag, "_wen"}, {1'b0, bus.RxWireDataWEn}, 2'b00);
            end
            chk({tag, "_ovf"}, {1'b0, overflow}, {1'b0, exp_ovf});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of run, expected finish by cycle 210");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [1:0] drain [5];
        drain = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10};

        rst = 1'b0;
        pins = 2'b10;
        rx_en = 1'b1;
        low_speed = 1'b0;
        bus.RxWireReady = 1'b1;
        repeat (3) tick();
        chk("rst_wen", {1'b0, bus.RxWireDataWEn}, 2'b00);
        chk("rst_data", bus.RxWireDataOut, 2'b00);
        chk("rst_ovf", {1'b0, overflow}, 2'b00);

        // Idle J from release, then a line edge that lands at cnt=3.
        rst = 1'b1;
        cyc = 0;
        expect_push(3, 2'b10);
        expect_push(5, 2'b10);
        expect_push(9, 2'b10);
        expect_push(13, 2'b10);
        expect_push(16, 2'b01);
        expect_push(20, 2'b01);
        run_free(11, "idle_j");
        pins = 2'b01;
        run_free(20, "resync");

        // Stalled consumer: head held, fills at cycle 32, 5th strobe at 36 overflows.
        bus.RxWireReady = 1'b0;
        while (cyc < 40) begin
            tick();
            chk("stall_wen", {1'b0, bus.RxWireDataWEn}, 2'b01);
            chk("stall_data", bus.RxWireDataOut, 2'b01);
            chk("stall_ovf", {1'b0, overflow}, {1'b0, cyc >= 36});
            if (cyc == 36) pins = 2'b10;
        end

        // Push and pop together while full at cycle 41, then drain.
        bus.RxWireReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("drain_wen", {1'b0, bus.RxWireDataWEn}, 2'b01);
            chk("drain_data", bus.RxWireDataOut, drain[i]);
            chk("drain_ovf", {1'b0, overflow}, 2'b01);
        end
        tick();
        chk("drained_wen", {1'b0, bus.RxWireDataWEn}, 2'b00);
        chk("drained_ovf", {1'b0, overflow}, 2'b01);

        // Refill two entries, then a one-clock disable flushes and clears overflow.
        bus.RxWireReady = 1'b0;
        while (cyc < 53) begin
            tick();
            chk("refill_wen", {1'b0, bus.RxWireDataWEn}, {1'b0, cyc >= 49});
            if (cyc >= 49) chk("refill_data", bus.RxWireDataOut, 2'b10);
            chk("refill_ovf", {1'b0, overflow}, 2'b01);
        end
        rx_en = 1'b0;
        tick();
        chk("flush_wen", {1'b0, bus.RxWireDataWEn}, 2'b00);
        chk("flush_ovf", {1'b0, overflow}, 2'b00);
        rx_en = 1'b1;
        exp_ovf = 1'b0;
        expect_push(57, 2'b10);
        run_free(57, "reenable");

        // Low speed, pins toggling every 32 clocks: one sample 16 clocks after each edge.
        bus.RxWireReady = 1'b1;
        low_speed = 1'b1;
        pins = 2'b01;
        expect_push(76, 2'b01);
        expect_push(108, 2'b10);
        expect_push(140, 2'b01);
        expect_push(172, 2'b10);
        run_free(89, "low_speed");
        pins = 2'b10;
        run_free(121, "low_speed");
        pins = 2'b01;
        run_free(153, "low_speed");
        pins = 2'b10;
        run_free(180, "low_speed");

        // One-clock SE0 glitch: unfiltered, it restarts the phase and is never sampled.
        pins = 2'b00;
        run_free(181, "glitch");
        pins = 2'b10;
        expect_push(200, 2'b10);
        run_free(210, "glitch");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
